// File: rtl/fdd_timing_pkg.sv
// Shared 300 MHz timing constants and generator state encoding used by the
// INDEX pulse generator and the INDEX frequency counter.
package fdd_timing_pkg;

    localparam int unsigned CLK_HZ               = 300_000_000;
    localparam int unsigned PERIOD_300RPM        = 60_000_000;
    localparam int unsigned PERIOD_360RPM        = 50_000_000;
    localparam int unsigned PERIOD_3600RPM       = 5_000_000;
    localparam int unsigned PERIOD_5400RPM       = 3_333_333;
    localparam int unsigned DEFAULT_PERIOD_CLKS  = PERIOD_300RPM;
    localparam int unsigned FLOPPY_HDD_THRESHOLD = 30_000_000;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SPINUP = 2'd1,
        ST_RUN    = 2'd2
    } gen_state_e;

endpackage

// File: rtl/index_pulse_gen_pulse_timer.sv
// Loadable down-counter whose registered output stays high for load_val
// clocks after a load; clear drops it immediately.
module pulse_timer #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             pulse
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        if (clear) begin
            cnt_d   = '0;
            pulse_d = 1'b0;
        end else if (load) begin
            cnt_d   = load_val;
            pulse_d = (load_val != '0);
        end else if (cnt_q != '0) begin
            cnt_d   = cnt_q - CNT_W'(1);
            pulse_d = (cnt_q > CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/index_pulse_gen.sv
// Programmable INDEX / hard-sector pulse transmitter for drive emulation and
// loopback self-test of the INDEX frequency counter.
module index_pulse_gen
    import fdd_timing_pkg::*;
#(
    parameter int          PERIOD_W       = 27,
    parameter int          WIDTH_W        = 24,
    parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_CLKS,
    parameter int          SECT_W         = 7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period_cfg,
    input  logic [WIDTH_W-1:0]  width_cfg,
    input  logic [SECT_W-1:0]   sectors_cfg,
    input  logic [PERIOD_W-1:0] sector_period_cfg,
    input  logic [3:0]          spinup_revs,
    output logic                index_out,
    output logic                sector_out,
    output logic                ready,
    output logic [15:0]         rev_count,
    output logic [SECT_W-1:0]   sector_num,
    output logic                cfg_error
);

    localparam logic [PERIOD_W-1:0] DEF_P = PERIOD_W'(DEFAULT_PERIOD);

    gen_state_e          state_q, state_d;
    logic [PERIOD_W-1:0] phase_q, phase_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] wid_q, wid_d;
    logic [PERIOD_W-1:0] sper_q, sper_d;
    logic [PERIOD_W-1:0] snext_q, snext_d;
    logic [SECT_W-1:0]   sect_q, sect_d;
    logic [SECT_W-1:0]   snum_q, snum_d;
    logic                sarm_q, sarm_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [15:0]         rev_q, rev_d;

    logic [PERIOD_W-1:0] new_per, new_wid, width_ext;
    logic                new_err, new_arm;
    logic                rev_start, idx_load, sec_load, tmr_clear, sec_clear;
    logic [PERIOD_W:0]   snext_sum;
    logic                more_sectors;
    logic                idx_pulse, sec_pulse;

    // Clamped view of the live config, only consumed when a revolution starts
    always_comb begin
        width_ext = PERIOD_W'(width_cfg);
        new_per   = (period_cfg < PERIOD_W'(2)) ? DEF_P : period_cfg;
        if (width_cfg == '0) begin
            new_wid = PERIOD_W'(1);
        end else if (width_ext >= new_per) begin
            new_wid = new_per - PERIOD_W'(1);
        end else begin
            new_wid = width_ext;
        end
        new_arm = (sectors_cfg >= SECT_W'(2)) && (sector_period_cfg != '0);
        new_err = (period_cfg < PERIOD_W'(2)) || (width_cfg == '0) ||
                  (width_ext >= new_per) ||
                  ((sectors_cfg >= SECT_W'(2)) && (sector_period_cfg == '0));
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        per_d     = per_q;
        wid_d     = wid_q;
        sect_d    = sect_q;
        sper_d    = sper_q;
        snext_d   = snext_q;
        sarm_d    = sarm_q;
        snum_d    = snum_q;
        rev_d     = rev_q;
        ready_d   = ready_q;
        err_d     = err_q;
        rev_start = 1'b0;
        idx_load  = 1'b0;
        sec_load  = 1'b0;
        tmr_clear = 1'b0;
        sec_clear = 1'b0;
        snext_sum = {1'b0, snext_q} + {1'b0, sper_q};
        // sector k = snum_q+1 is pulsing now; another follows only if k+1 <= S-1
        more_sectors = ({2'b00, snum_q} + (SECT_W+2)'(3)) <= {2'b00, sect_q};

        case (state_q)
            ST_OFF: begin
                if (enable) begin
                    rev_start = 1'b1;
                    phase_d   = '0;
                    rev_d     = 16'd1;
                    err_d     = new_err;
                    ready_d   = (spinup_revs == 4'd0);
                    state_d   = (spinup_revs == 4'd0) ? ST_RUN : ST_SPINUP;
                end
            end
            ST_SPINUP, ST_RUN: begin
                if (!enable) begin
                    state_d   = ST_OFF;
                    phase_d   = '0;
                    ready_d   = 1'b0;
                    snum_d    = '0;
                    sarm_d    = 1'b0;
                    tmr_clear = 1'b1;
                end else if (phase_q == per_q - PERIOD_W'(1)) begin
                    rev_start = 1'b1;
                    phase_d   = '0;
                    rev_d     = rev_q + 16'd1;
                    err_d     = err_q | new_err;
                    if ((state_q == ST_SPINUP) && (rev_d > {12'd0, spinup_revs})) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + PERIOD_W'(1);
                    if (sarm_q && (phase_d == snext_q)) begin
                        sec_load = 1'b1;
                        snum_d   = snum_q + SECT_W'(1);
                        if (more_sectors && !snext_sum[PERIOD_W]) begin
                            snext_d = snext_sum[PERIOD_W-1:0];
                        end else begin
                            sarm_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d   = ST_OFF;
                ready_d   = 1'b0;
                tmr_clear = 1'b1;
            end
        endcase

        // INDEX wins: a sector pulse still running at the wrap is cut short
        if (rev_start) begin
            per_d     = new_per;
            wid_d     = new_wid;
            sect_d    = sectors_cfg;
            sper_d    = sector_period_cfg;
            snext_d   = sector_period_cfg;
            sarm_d    = new_arm;
            snum_d    = '0;
            idx_load  = 1'b1;
            sec_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_OFF;
            phase_q <= '0;
            per_q   <= '0;
            wid_q   <= '0;
            sect_q  <= '0;
            sper_q  <= '0;
            snext_q <= '0;
            sarm_q  <= 1'b0;
            snum_q  <= '0;
            rev_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            per_q   <= per_d;
            wid_q   <= wid_d;
            sect_q  <= sect_d;
            sper_q  <= sper_d;
            snext_q <= snext_d;
            sarm_q  <= sarm_d;
            snum_q  <= snum_d;
            rev_q   <= rev_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    pulse_timer #(.CNT_W(PERIOD_W)) u_index_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (tmr_clear),
        .load     (idx_load),
        .load_val (new_wid),
        .pulse    (idx_pulse)
    );

    pulse_timer #(.CNT_W(PERIOD_W)) u_sector_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (tmr_clear | sec_clear),
        .load     (sec_load),
        .load_val (wid_q),
        .pulse    (sec_pulse)
    );

    assign index_out  = idx_pulse;
    assign sector_out = sec_pulse & ~idx_pulse;
    assign ready      = ready_q;
    assign rev_count  = rev_q;
    assign sector_num = snum_q;
    assign cfg_error  = err_q;

endmodule

// File: tb/tb_index_pulse_gen.sv
// Scoreboard bench for index_pulse_gen: a revolution-level model queues the
// expected INDEX/SECTOR rises, a monitor pops and compares them as they occur.
module tb_index_pulse_gen;
    import fdd_timing_pkg::*;

    localparam int PW = 27;
    localparam int WW = 24;
    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] period_cfg = '0;
    logic [WW-1:0] width_cfg = '0;
    logic [SW-1:0] sectors_cfg = '0;
    logic [PW-1:0] sector_period_cfg = '0;
    logic [3:0]    spinup_revs = '0;
    logic          index_out, sector_out, ready, cfg_error;
    logic [15:0]   rev_count;
    logic [SW-1:0] sector_num;

    typedef struct {
        int period;
        int width;
        int sectors;
        int sper;
    } cfg_t;

    typedef struct {
        int kind;
        int cyc;
        int rev;
        int rdy;
        int snum;
        int err;
        int width;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    bit  prev_idx = 1'b0, prev_sec = 1'b0;
    int  idx_len = 0, sec_len = 0, idx_w = -1, sec_w = -1;

    index_pulse_gen dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .period_cfg        (period_cfg),
        .width_cfg         (width_cfg),
        .sectors_cfg       (sectors_cfg),
        .sector_period_cfg (sector_period_cfg),
        .spinup_revs       (spinup_revs),
        .index_out         (index_out),
        .sector_out        (sector_out),
        .ready             (ready),
        .rev_count         (rev_count),
        .sector_num        (sector_num),
        .cfg_error         (cfg_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
        end
    endtask

    function automatic int effPeriod(input cfg_t k);
        return (k.period < 2) ? int'(DEFAULT_PERIOD_CLKS) : k.period;
    endfunction

    function automatic int effWidth(input cfg_t k);
        if (k.width == 0) return 1;
        if (k.width >= effPeriod(k)) return effPeriod(k) - 1;
        return k.width;
    endfunction

    function automatic int clampErr(input cfg_t k);
        return (k.period < 2 || k.width == 0 || k.width >= effPeriod(k) ||
                (k.sectors >= 2 && k.sper == 0)) ? 1 : 0;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Enable is seen at the edge after cycle s; revs start at s+1, s+1+P, ...
    // Cycle s+dur is the last enabled cycle, outputs are forced low from e=s+dur+1.
    task automatic buildExpected(input int s, input int dur, input cfg_t a, input cfg_t b,
                                 input int tc, input int spin,
                                 output int last_rev, output int last_err);
        int   c, e, rev, err, p, w, bnd;
        cfg_t k;
        ev_t  ev;
        c   = s + 1;
        e   = s + dur + 1;
        rev = 0;
        err = 0;
        while (c <= s + dur) begin
            k   = (c > tc) ? b : a;
            p   = effPeriod(k);
            w   = effWidth(k);
            rev = rev + 1;
            err = err | clampErr(k);
            ev  = '{0, c, rev & 16'hFFFF, (rev > spin) ? 1 : 0, 0, err, imin(w, e - c)};
            exp_q.push_back(ev);
            if (k.sectors >= 2 && k.sper > 0) begin
                for (int j = 1; j < k.sectors; j++) begin
                    bnd = j * k.sper;
                    if (bnd >= p || c + bnd > s + dur) break;
                    ev = '{1, c + bnd, rev & 16'hFFFF, (rev > spin) ? 1 : 0, j, err,
                           imin(imin(w, p - bnd), e - c - bnd)};
                    exp_q.push_back(ev);
                end
            end
            c = c + p;
        end
        last_rev = rev;
        last_err = err;
    endtask

    task automatic setCfg(input cfg_t k);
        period_cfg        = PW'(k.period);
        width_cfg         = WW'(k.width);
        sectors_cfg       = SW'(k.sectors);
        sector_period_cfg = PW'(k.sper);
    endtask

    task automatic popCompare(input int kind, output int w);
        ev_t ev;
        if (exp_q.size() == 0) begin
            checkOutput(kind == 0 ? "unexpected_index" : "unexpected_sector", 1, 0);
            w = -1;
            return;
        end
        ev = exp_q.pop_front();
        checkOutput("event_kind", kind, ev.kind);
        checkOutput("event_cycle", cyc, ev.cyc);
        checkOutput("rev_count", rev_count, ev.rev);
        checkOutput("ready", ready, ev.rdy);
        checkOutput("sector_num", sector_num, ev.snum);
        checkOutput("cfg_error", cfg_error, ev.err);
        w = ev.width;
    endtask

    // Monitor: pops an expected event on each rise and checks the pulse width on the fall
    initial begin : monitor
        int w;
        forever begin
            @(negedge clk);
            if (index_out || sector_out) checkOutput("index_sector_overlap", index_out && sector_out, 0);
            if (index_out && !prev_idx) begin
                popCompare(0, w);
                idx_w   = w;
                idx_len = 1;
            end else if (index_out) begin
                idx_len++;
            end else if (prev_idx && idx_w >= 0) begin
                checkOutput("index_width", idx_len, idx_w);
            end
            if (sector_out && !prev_sec) begin
                popCompare(1, w);
                sec_w   = w;
                sec_len = 1;
            end else if (sector_out) begin
                sec_len++;
            end else if (prev_sec && sec_w >= 0) begin
                checkOutput("sector_width", sec_len, sec_w);
            end
            prev_idx = index_out;
            prev_sec = sector_out;
        end
    end

    task automatic applyStimulus(input cfg_t a, input cfg_t b, input int tc_rel, input int dur,
                                 input int spin, input bit use_reset);
        int s, last_rev, last_err;
        @(negedge clk);
        s = cyc;
        setCfg(a);
        spinup_revs = 4'(spin);
        enable      = 1'b1;
        buildExpected(s, dur, a, b, (tc_rel > 0) ? s + tc_rel : 0, spin, last_rev, last_err);
        for (int i = 1; i <= dur; i++) begin
            @(negedge clk);
            if (i == tc_rel) setCfg(b);
        end
        enable = 1'b0;
        if (use_reset) reset_n = 1'b0;
        @(negedge clk);
        checkOutput("off_index_out", index_out, 0);
        checkOutput("off_sector_out", sector_out, 0);
        checkOutput("off_ready", ready, 0);
        checkOutput("off_rev_count", rev_count, use_reset ? 0 : last_rev);
        checkOutput("off_cfg_error", cfg_error, use_reset ? 0 : last_err);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic cfg_t randCfg();
        cfg_t k;
        k.period = int'($urandom_range(200, 20));
        case ($urandom_range(5, 0))
            0:       k.width = 0;
            1:       k.width = k.period + int'($urandom_range(50, 0));
            default: k.width = int'($urandom_range(k.period / 2, 1));
        endcase
        k.sectors = int'($urandom_range(6, 0));
        k.sper    = ($urandom_range(5, 0) == 0) ? 0 :
                    int'($urandom_range(k.period, effWidth(k) + 1));
        return k;
    endfunction

    initial begin : watchdog
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        cfg_t a, b;
        int   dur, tc;
        repeat (3) @(negedge clk);
        checkOutput("reset_index_out", index_out, 0);
        checkOutput("reset_sector_out", sector_out, 0);
        checkOutput("reset_ready", ready, 0);
        checkOutput("reset_rev_count", rev_count, 0);
        checkOutput("reset_sector_num", sector_num, 0);
        checkOutput("reset_cfg_error", cfg_error, 0);
        reset_n = 1'b1;

        $display("[TB] basic run, spin-up of two revolutions");
        a = '{1000, 100, 0, 0};
        applyStimulus(a, a, 0, 2300, 2, 1'b0);

        $display("[TB] hard-sector runs");
        a = '{1000, 10, 4, 250};
        applyStimulus(a, a, 0, 1100, 0, 1'b0);
        a = '{1000, 10, 4, 400};
        applyStimulus(a, a, 0, 1100, 1, 1'b0);
        a = '{300, 50, 3, 280};
        applyStimulus(a, a, 0, 650, 0, 1'b0);
        a = '{300, 10, 4, 300};
        applyStimulus(a, a, 0, 650, 0, 1'b0);

        $display("[TB] clamp and substitution cases");
        a = '{1, 50, 0, 0};
        applyStimulus(a, a, 0, 300, 0, 1'b0);
        a = '{200, 0, 0, 0};
        applyStimulus(a, a, 0, 450, 0, 1'b0);
        a = '{1000, 2000, 0, 0};
        applyStimulus(a, a, 0, 1100, 0, 1'b0);
        a = '{300, 20, 4, 0};
        applyStimulus(a, a, 0, 650, 0, 1'b0);

        $display("[TB] mid-revolution period change");
        a = '{1000, 100, 0, 0};
        b = '{500, 100, 0, 0};
        applyStimulus(a, b, 301, 1800, 1, 1'b0);

        $display("[TB] disable mid-pulse, re-enable, reset mid-run");
        a = '{1000, 100, 0, 0};
        applyStimulus(a, a, 0, 1050, 0, 1'b0);
        a = '{400, 30, 3, 150};
        applyStimulus(a, a, 0, 600, 1, 1'b1);

        $display("[TB] randomized runs");
        for (int r = 0; r < 25; r++) begin
            a   = randCfg();
            b   = a;
            tc  = 0;
            dur = int'($urandom_range(3 * a.period + a.period / 2, a.period / 2));
            if ($urandom_range(2, 0) == 0) begin
                b  = randCfg();
                tc = int'($urandom_range(dur - 1, 1));
            end
            applyStimulus(a, b, tc, dur, int'($urandom_range(3, 0)), $urandom_range(4, 0) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
